// File: rtl/kernel_pr_write_back_burst.sv
// Write-back stage of the kernel_pr dataflow region: one start token = one job of
// AXI-style write bursts. Optional bresp error flag under KERNEL_PR_WB_BRESP_CHECK_EN.
module kernel_pr_write_back_burst #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64,
  parameter int LEN_WIDTH  = 32,
  parameter int BURST_MAX  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_empty_n,
  output logic                  start_read,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  num_words,
  input  logic                  din_empty_n,
  output logic                  din_read,
  input  logic [DATA_WIDTH-1:0] din_dout,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wlast,
  input  logic                  bvalid,
  output logic                  bready,
  output logic                  ap_idle,
  output logic                  ap_done
`ifdef KERNEL_PR_WB_BRESP_CHECK_EN
  ,
  input  logic [1:0]            bresp,
  output logic                  err
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_DONE} state_t;

  localparam int                   BYTE_SHIFT    = $clog2(DATA_WIDTH / 8);
  localparam logic [LEN_WIDTH-1:0] BURST_MAX_LEN = LEN_WIDTH'(BURST_MAX);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [LEN_WIDTH-1:0]    remaining;
  logic [LEN_WIDTH-1:0]    rem_after;
  logic [8:0]              burst;
  logic [8:0]              beat;
  logic                    last_beat;

  function automatic logic [8:0] clip_burst(input logic [LEN_WIDTH-1:0] words);
    if (words >= BURST_MAX_LEN) return 9'(BURST_MAX);
    else                        return 9'(words);
  endfunction

  assign rem_after = remaining - LEN_WIDTH'(burst);
  assign last_beat = (beat == burst - 9'd1);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_empty_n) state_nxt = (num_words == '0) ? S_DONE : S_ADDR;
      S_ADDR: if (awready) state_nxt = S_DATA;
      S_DATA: if (din_empty_n && wready && last_beat) state_nxt = S_RESP;
      S_RESP: if (bvalid) state_nxt = (rem_after == '0) ? S_DONE : S_ADDR;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no latch is inferred;
  // handshake outputs are also masked by reset so no FIFO pop happens in the reset cycle.
  always_comb begin
    start_read = 1'b0;
    din_read   = 1'b0;
    awvalid    = 1'b0;
    awaddr     = '0;
    awlen      = '0;
    wvalid     = 1'b0;
    wdata      = '0;
    wlast      = 1'b0;
    bready     = 1'b0;
    ap_done    = 1'b0;
    ap_idle    = (state == S_IDLE);
    if (!reset) begin
      case (state)
        S_IDLE: start_read = start_empty_n;
        S_ADDR: begin
          awvalid = 1'b1;
          awaddr  = cur_addr;
          awlen   = 8'(burst - 9'd1);
        end
        S_DATA: begin
          wvalid   = din_empty_n;
          wdata    = din_dout;
          wlast    = last_beat;
          din_read = din_empty_n & wready;
        end
        S_RESP:  bready  = 1'b1;
        S_DONE:  ap_done = 1'b1;
        default: ;
      endcase
    end
  end

  // burst is captured on every entry into ADDR, so awaddr/awlen stay stable while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_addr  <= '0;
      remaining <= '0;
      burst     <= '0;
      beat      <= '0;
    end else begin
      case (state)
        S_IDLE: if (start_empty_n) begin
          cur_addr  <= base_addr;
          remaining <= num_words;
          burst     <= clip_burst(num_words);
          beat      <= '0;
        end
        S_DATA: if (din_empty_n && wready) beat <= beat + 9'd1;
        S_RESP: if (bvalid) begin
          remaining <= rem_after;
          cur_addr  <= cur_addr + (ADDR_WIDTH'(burst) << BYTE_SHIFT);
          burst     <= clip_burst(rem_after);
          beat      <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef KERNEL_PR_WB_BRESP_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)                                         err <= 1'b0;
    else if (state == S_RESP && bvalid && bresp != 2'b00) err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_kernel_pr_write_back_burst.sv
// Self-checking bench for kernel_pr_write_back_burst: randomized slave/FIFO behaviour
// against a job-level burst model. Define KERNEL_PR_WB_BRESP_CHECK_EN to test the err flag.
module tb_kernel_pr_write_back_burst;

  localparam int DW = 512;
  localparam int AW = 64;
  localparam int LW = 32;
  localparam int BMAX = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_empty_n = 1'b0;
  logic          start_read;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] num_words = '0;
  logic          din_empty_n = 1'b0;
  logic          din_read;
  logic [DW-1:0] din_dout = '0;
  logic          awvalid;
  logic          awready = 1'b0;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic          wvalid;
  logic          wready = 1'b0;
  logic [DW-1:0] wdata;
  logic          wlast;
  logic          bvalid = 1'b0;
  logic          bready;
  logic          ap_idle;
  logic          ap_done;
`ifdef KERNEL_PR_WB_BRESP_CHECK_EN
  logic [1:0]    bresp = 2'b00;
  logic          err;
`endif

  kernel_pr_write_back_burst #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .BURST_MAX(BMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .start_empty_n(start_empty_n), .start_read(start_read),
    .base_addr(base_addr), .num_words(num_words),
    .din_empty_n(din_empty_n), .din_read(din_read), .din_dout(din_dout),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
    .bvalid(bvalid), .bready(bready),
    .ap_idle(ap_idle), .ap_done(ap_done)
`ifdef KERNEL_PR_WB_BRESP_CHECK_EN
    , .bresp(bresp), .err(err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Shared state between the stimulus/monitor process and the job sequencer.
  logic          rst_req = 1'b1;
  logic          tok_pending = 1'b0;
  logic [AW-1:0] tok_base = '0;
  logic [LW-1:0] tok_n = '0;
  bit            stall_en = 1'b0;
  int            err_burst = -1;
  logic [DW-1:0] fifo_q[$];
  logic [71:0]   got_aw[$];
  logic [DW-1:0] got_w[$];
  bit            got_last[$];
  int            cyc = 0, pend_b = 0, b_seen = 0, done_cnt = 0, read_cnt = 0;
  int            done_cyc = 0, last_b_cyc = 0;
  bit            aw_stall_prev = 1'b0;
  logic [AW-1:0] prev_awaddr = '0;
  logic [7:0]    prev_awlen = '0;
  bit            err_next_chk = 1'b0;

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Drive inputs right after the falling edge, then sample what the next rising edge will commit.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      reset         = rst_req;
      start_empty_n = tok_pending;
      base_addr     = tok_base;
      num_words     = tok_n;
      din_empty_n   = (fifo_q.size() > 0) && !(stall_en && $urandom_range(0, 3) == 0);
      din_dout      = (fifo_q.size() > 0) ? fifo_q[0] : '0;
      awready       = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      wready        = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      bvalid        = (pend_b > 0) && (stall_en ? ($urandom_range(0, 2) == 0) : 1'b1);
`ifdef KERNEL_PR_WB_BRESP_CHECK_EN
      bresp         = (b_seen == err_burst) ? 2'b10 : 2'b00;
`endif
      #1;
      if (!reset) begin
`ifdef KERNEL_PR_WB_BRESP_CHECK_EN
        if (err_next_chk) check("err_rise", err, 1);
        err_next_chk = bvalid && bready && bresp != 2'b00;
`endif
        check("pop_vs_beat", din_read, wvalid & wready);
        if (wvalid) check("no_bubble", din_empty_n, 1);
        if (aw_stall_prev) check("aw_hold", {awvalid, awaddr, awlen}, {1'b1, prev_awaddr, prev_awlen});
        if (awvalid) check("aw_alone", wvalid | bready, 0);
        if (awvalid && awready) got_aw.push_back({awaddr, awlen});
        if (wvalid && wready) begin
          got_w.push_back(wdata);
          got_last.push_back(wlast);
          if (wlast) pend_b++;
        end
        if (din_read) begin
          if (fifo_q.size() > 0) void'(fifo_q.pop_front());
          else check("pop_empty", din_read, 0);
        end
        if (bvalid && bready) begin
          pend_b--;
          b_seen++;
          last_b_cyc = cyc;
        end
        if (ap_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (start_read) begin
          tok_pending = 1'b0;
          read_cnt++;
        end
        aw_stall_prev = awvalid && !awready;
        prev_awaddr   = awaddr;
        prev_awlen    = awlen;
      end else begin
        aw_stall_prev = 1'b0;
      end
    end
  end

  task automatic wait_done();
    int t = 0;
    while (done_cnt == 0 && t < 20000) begin
      @(negedge clk); #2;
      t++;
    end
    if (done_cnt == 0) check("done_timeout", 0, 1);
    repeat (3) begin @(negedge clk); #2; end
  endtask

  // Job-level model: split n words into bursts of at most BMAX beats at consecutive addresses.
  task automatic run_job(input string name, input logic [AW-1:0] base, input int n, input int bad);
    logic [71:0]   exp_aw[$];
    logic [DW-1:0] exp_w[$];
    bit            exp_last[$];
    logic [AW-1:0] a = base;
    int            rem = n;
    got_aw.delete(); got_w.delete(); got_last.delete();
    done_cnt = 0; read_cnt = 0; b_seen = 0; err_burst = bad;
    while (rem > 0) begin
      int b = (rem < BMAX) ? rem : BMAX;
      exp_aw.push_back({a, 8'(b - 1)});
      for (int i = 0; i < b; i++) exp_last.push_back(i == b - 1);
      a   = a + AW'(b * (DW / 8));
      rem = rem - b;
    end
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] w = rand_word();
      fifo_q.push_back(w);
      exp_w.push_back(w);
    end
    tok_base = base; tok_n = LW'(n); tok_pending = 1'b1;
    wait_done();
    check({name, "_tokens"}, read_cnt, 1);
    check({name, "_done_cnt"}, done_cnt, 1);
    check({name, "_aw_cnt"}, got_aw.size(), exp_aw.size());
    for (int i = 0; i < got_aw.size() && i < exp_aw.size(); i++)
      check($sformatf("%s_aw%0d", name, i), got_aw[i], exp_aw[i]);
    check({name, "_w_cnt"}, got_w.size(), n);
    for (int i = 0; i < got_w.size() && i < n; i++) begin
      check($sformatf("%s_wdata%0d", name, i), got_w[i], exp_w[i]);
      check($sformatf("%s_wlast%0d", name, i), got_last[i], exp_last[i]);
    end
    check({name, "_fifo_drained"}, fifo_q.size(), 0);
    if (n > 0) check({name, "_done_lat"}, done_cyc - last_b_cyc, 1);
    err_burst = -1;
  endtask

  initial begin
    int t;
    repeat (3) begin @(negedge clk); #2; end
    check("rst_idle", ap_idle, 1);
    check("rst_outs", {start_read, din_read, awvalid, wvalid, wlast, bready, ap_done}, 0);
    check("rst_aw", {awaddr, awlen}, 0);
`ifdef KERNEL_PR_WB_BRESP_CHECK_EN
    check("rst_err", err, 0);
`endif
    rst_req = 1'b0;
    @(negedge clk); #2;
    check("post_rst_idle", ap_idle, 1);

    run_job("short", 64'h1000, 3, -1);
    run_job("multi", 64'h1000, 130, -1);
    run_job("zero", 64'h5000, 0, -1);
    run_job("exact", 64'h2000, 64, -1);
    run_job("wrap", 64'hFFFF_FFFF_FFFF_F000, 130, -1);
    stall_en = 1'b1;
    run_job("stall10", 64'h3000, 10, -1);
    for (int j = 0; j < 4; j++)
      run_job($sformatf("rnd%0d", j), {$urandom, $urandom} & ~64'h3f, $urandom_range(1, 150), -1);
    stall_en = 1'b0;

    // Reset in the middle of a 64-beat data phase.
    got_w.delete();
    for (int i = 0; i < 64; i++) fifo_q.push_back(rand_word());
    tok_base = 64'h4000; tok_n = 64; tok_pending = 1'b1;
    t = 0;
    while (got_w.size() < 10 && t < 1000) begin @(negedge clk); #2; t++; end
    check("mid_reach_data", got_w.size() >= 10, 1);
    rst_req = 1'b1; tok_pending = 1'b0;
    @(negedge clk); #2;
    check("mid_rst_quiet", {din_read, wvalid, awvalid, start_read}, 0);
    rst_req = 1'b0;
    @(negedge clk); #2;
    check("mid_rst_idle", ap_idle, 1);
    check("mid_rst_outs", {din_read, wvalid, awvalid, bready, ap_done, start_read}, 0);
    fifo_q.delete(); pend_b = 0;
    run_job("after_rst", 64'h8000, 5, -1);

`ifdef KERNEL_PR_WB_BRESP_CHECK_EN
    check("err_clear", err, 0);
    run_job("bresp", 64'h1000, 130, 1);
    check("err_sticky", err, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
